// File: rtl/hazard_unit_mc.sv
// Hazard/bypass controller for the 5-stage RV32 pipeline: operand bypass, qualified load-use
// detection, multi-cycle MDU hold sequencing, reset-forced flushes and saturating perf counters.
module hazard_unit_mc #(
    parameter int REG_AW  = 5,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] rs1_d_i,
    input  logic [REG_AW-1:0] rs2_d_i,
    input  logic              rs1_use_d_i,
    input  logic              rs2_use_d_i,
    input  logic [REG_AW-1:0] rs1_e_i,
    input  logic [REG_AW-1:0] rs2_e_i,
    input  logic [REG_AW-1:0] rd_e_i,
    input  logic [REG_AW-1:0] rd_m_i,
    input  logic [REG_AW-1:0] rd_w_i,
    input  logic              reg_write_e_i,
    input  logic              reg_write_m_i,
    input  logic              reg_write_w_i,
    input  logic              result_src_e_i,
    input  logic              pc_src_e_i,
    input  logic              mdu_start_e_i,
    input  logic              perf_clr_i,
    output logic [1:0]        forward_a_o,
    output logic [1:0]        forward_b_o,
    output logic              stall_f_o,
    output logic              stall_d_o,
    output logic              stall_e_o,
    output logic              flush_d_o,
    output logic              flush_e_o,
    output logic              flush_m_o,
    output logic              mdu_busy_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef enum logic {
        IDLE,
        BUSY
    } mdu_state_e;

    // cnt holds the number of BUSY cycles still to run after the start cycle
    localparam logic [7:0]       BUSY_CYCLES = 8'(MDU_LAT - 2);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    mdu_state_e       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             hold_q, hold_d;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0] flushCnt_q, flushCnt_d;
    logic             mduStall;
    logic             loadUse;

    function automatic logic [1:0] fwdSel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rdM,
        input logic              wrM,
        input logic [REG_AW-1:0] rdW,
        input logic              wrW
    );
        if (rs != '0 && rs == rdM && wrM) begin
            return 2'b10;
        end else if (rs != '0 && rs == rdW && wrW) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    // hold_q blocks re-triggering on the same op that just held E through its last stall cycle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mduStall = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mdu_start_e_i && !pc_src_e_i && !hold_q) begin
                    mduStall = 1'b1;
                    if (BUSY_CYCLES != 8'd0) begin
                        state_d = BUSY;
                        cnt_d   = BUSY_CYCLES;
                    end
                end
            end
            BUSY: begin
                mduStall = 1'b1;
                if (cnt_q <= 8'd1) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        hold_d = mdu_start_e_i & mduStall;
    end

    assign loadUse = result_src_e_i & reg_write_e_i & (rd_e_i != '0) &
                     ((rs1_use_d_i & (rs1_d_i == rd_e_i)) | (rs2_use_d_i & (rs2_d_i == rd_e_i)));

    always_comb begin
        forward_a_o = 2'b00;
        forward_b_o = 2'b00;
        stall_f_o   = 1'b0;
        stall_d_o   = 1'b0;
        stall_e_o   = 1'b0;
        flush_d_o   = 1'b1;
        flush_e_o   = 1'b1;
        flush_m_o   = 1'b1;
        if (!rst_i) begin
            forward_a_o = fwdSel(rs1_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);
            forward_b_o = fwdSel(rs2_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);
            stall_f_o   = mduStall | loadUse;
            stall_d_o   = mduStall | loadUse;
            stall_e_o   = mduStall;
            flush_m_o   = mduStall;
            flush_d_o   = pc_src_e_i & ~mduStall;
            flush_e_o   = (loadUse | pc_src_e_i) & ~mduStall;
        end
    end

    always_comb begin
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;
        if (perf_clr_i) begin
            stallCnt_d = '0;
            flushCnt_d = '0;
        end else begin
            if (stall_f_o && stallCnt_q != CNT_MAX) stallCnt_d = stallCnt_q + 1'b1;
            if (flush_d_o && flushCnt_q != CNT_MAX) flushCnt_d = flushCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            hold_q     <= 1'b0;
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    assign mdu_busy_o  = (state_q == BUSY);
    assign stall_cnt_o = stallCnt_q;
    assign flush_cnt_o = flushCnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Testbench for hazard_unit_mc: directed table, multi-cycle MDU/counter/reset sequences and random
// stimulus, all compared against a cycle-level reference model.
module tb_hazard_unit_mc;

    localparam int AW   = 5;
    localparam int LAT  = 4;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic          use1, use2, rwE, rwM, rwW, ldE, pcSrc, mduStart, perfClr;
    logic [1:0]    fwdA, fwdB;
    logic          stallF, stallD, stallE, flushD, flushE, flushM, mduBusy;
    logic [CW-1:0] stallCnt, flushCnt;

    always #5 clk = ~clk;

    hazard_unit_mc #(.REG_AW(AW), .MDU_LAT(LAT), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst),
        .rs1_d_i(rs1D), .rs2_d_i(rs2D), .rs1_use_d_i(use1), .rs2_use_d_i(use2),
        .rs1_e_i(rs1E), .rs2_e_i(rs2E), .rd_e_i(rdE), .rd_m_i(rdM), .rd_w_i(rdW),
        .reg_write_e_i(rwE), .reg_write_m_i(rwM), .reg_write_w_i(rwW),
        .result_src_e_i(ldE), .pc_src_e_i(pcSrc), .mdu_start_e_i(mduStart), .perf_clr_i(perfClr),
        .forward_a_o(fwdA), .forward_b_o(fwdB),
        .stall_f_o(stallF), .stall_d_o(stallD), .stall_e_o(stallE),
        .flush_d_o(flushD), .flush_e_o(flushE), .flush_m_o(flushM),
        .mdu_busy_o(mduBusy), .stall_cnt_o(stallCnt), .flush_cnt_o(flushCnt)
    );

    typedef struct {
        logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic          use1, use2, rwe, rwm, rww, ld, pc, start, clr, rst;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [1:0] fa, fb;
        logic       stallF, flushD, flushE;
    } vec_t;

    int    nVectors = 0;
    int    nMiscompares = 0;
    // model: remaining stall cycles of the running MDU op, plus the "same op still in E" flag
    int    mRem = 0;
    bit    mBlocked = 0;
    int    mStallCnt = 0;
    int    mFlushCnt = 0;
    bit    mMdu, mLw, mStallF, mFlushD;
    stim_t cur;

    function automatic stim_t idleStim();
        stim_t s;
        s.rs1d = '0; s.rs2d = '0; s.rs1e = '0; s.rs2e = '0; s.rde = '0; s.rdm = '0; s.rdw = '0;
        s.use1 = 0; s.use2 = 0; s.rwe = 0; s.rwm = 0; s.rww = 0;
        s.ld = 0; s.pc = 0; s.start = 0; s.clr = 0; s.rst = 0;
        return s;
    endfunction

    function automatic stim_t randStim(input bit prevStart);
        stim_t s;
        s.rs1d = 5'($urandom_range(0, 3)); s.rs2d = 5'($urandom_range(0, 3));
        s.rs1e = 5'($urandom_range(0, 3)); s.rs2e = 5'($urandom_range(0, 3));
        s.rde  = 5'($urandom_range(0, 3)); s.rdm  = 5'($urandom_range(0, 3));
        s.rdw  = 5'($urandom_range(0, 3));
        s.use1 = 1'($urandom_range(0, 1)); s.use2 = 1'($urandom_range(0, 1));
        s.rwe  = 1'($urandom_range(0, 1)); s.rwm  = 1'($urandom_range(0, 1));
        s.rww  = 1'($urandom_range(0, 1)); s.ld   = 1'($urandom_range(0, 1));
        s.pc    = ($urandom_range(0, 7) == 0);
        s.start = prevStart ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        s.clr   = ($urandom_range(0, 31) == 0);
        s.rst   = ($urandom_range(0, 63) == 0);
        return s;
    endfunction

    function automatic logic [1:0] fwdRef(input logic [AW-1:0] rs, input stim_t s);
        if (rs == 0) return 2'b00;
        if (s.rwm && rs == s.rdm) return 2'b10;
        if (s.rww && rs == s.rdw) return 2'b01;
        return 2'b00;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        logic [1:0] eFa, eFb;
        bit eStE, eFlD, eFlE, eFlM;
        @(negedge clk);
        cur = s;
        rst = s.rst; rs1D = s.rs1d; rs2D = s.rs2d; rs1E = s.rs1e; rs2E = s.rs2e;
        rdE = s.rde; rdM = s.rdm; rdW = s.rdw; use1 = s.use1; use2 = s.use2;
        rwE = s.rwe; rwM = s.rwm; rwW = s.rww; ldE = s.ld; pcSrc = s.pc;
        mduStart = s.start; perfClr = s.clr;
        #1;
        mLw  = s.ld && s.rwe && s.rde != 0 &&
               ((s.use1 && s.rs1d == s.rde) || (s.use2 && s.rs2d == s.rde));
        mMdu = (mRem > 0) || (s.start && !s.pc && !mBlocked);
        if (s.rst) begin
            eFa = 0; eFb = 0; mStallF = 0; eStE = 0; eFlD = 1; eFlE = 1; eFlM = 1;
        end else begin
            eFa = fwdRef(s.rs1e, s); eFb = fwdRef(s.rs2e, s);
            mStallF = mMdu || mLw; eStE = mMdu; eFlM = mMdu;
            eFlD = s.pc && !mMdu; eFlE = (mLw || s.pc) && !mMdu;
        end
        mFlushD = eFlD;
        checkOutput("forward_a", 16'(fwdA), 16'(eFa));
        checkOutput("forward_b", 16'(fwdB), 16'(eFb));
        checkOutput("stall_f", 16'(stallF), 16'(mStallF));
        checkOutput("stall_d", 16'(stallD), 16'(mStallF));
        checkOutput("stall_e", 16'(stallE), 16'(eStE));
        checkOutput("flush_d", 16'(flushD), 16'(eFlD));
        checkOutput("flush_e", 16'(flushE), 16'(eFlE));
        checkOutput("flush_m", 16'(flushM), 16'(eFlM));
        if (!s.rst) begin
            checkOutput("mdu_busy", 16'(mduBusy), 16'(mRem > 0));
            checkOutput("stall_cnt", 16'(stallCnt), 16'(mStallCnt));
            checkOutput("flush_cnt", 16'(flushCnt), 16'(mFlushCnt));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (cur.rst) begin
            mRem = 0; mBlocked = 0; mStallCnt = 0; mFlushCnt = 0;
        end else begin
            mBlocked = cur.start && mMdu;
            if (mRem > 0) mRem--;
            else if (mMdu) mRem = LAT - 2;
            if (cur.clr) begin
                mStallCnt = 0; mFlushCnt = 0;
            end else begin
                if (mStallF && mStallCnt < CMAX) mStallCnt++;
                if (mFlushD && mFlushCnt < CMAX) mFlushCnt++;
            end
        end
    endtask

    task automatic step(input stim_t s);
        applyStimulus(s);
        advance();
    endtask

    initial begin
        vec_t  tbl[10];
        stim_t s, lwS, clrS, startS, rstS;
        bit    prevStart;
        bit    expStE[8], expBusy[8], startSeq[8];

        for (int i = 0; i < 10; i++) begin
            tbl[i].s = idleStim();
            tbl[i].fa = 0; tbl[i].fb = 0; tbl[i].stallF = 0; tbl[i].flushD = 0; tbl[i].flushE = 0;
        end
        tbl[0].s.rs1e = 5; tbl[0].s.rdm = 5; tbl[0].s.rdw = 5; tbl[0].s.rwm = 1; tbl[0].s.rww = 1;
        tbl[0].fa = 2'b10;
        tbl[1].s = tbl[0].s; tbl[1].s.rs1e = 0;
        tbl[2].s.rs1e = 5; tbl[2].s.rs2e = 5; tbl[2].s.rdm = 5; tbl[2].s.rdw = 5; tbl[2].s.rww = 1;
        tbl[2].fa = 2'b01; tbl[2].fb = 2'b01;
        tbl[3].s.rs2e = 9; tbl[3].s.rdm = 9; tbl[3].s.rwm = 1;
        tbl[3].s.rs1e = 3; tbl[3].s.rdw = 3; tbl[3].s.rww = 1;
        tbl[3].fa = 2'b01; tbl[3].fb = 2'b10;
        tbl[4].s.ld = 1; tbl[4].s.rwe = 1; tbl[4].s.rde = 7; tbl[4].s.rs2d = 7; tbl[4].s.use2 = 1;
        tbl[4].stallF = 1; tbl[4].flushE = 1;
        tbl[5].s = tbl[4].s; tbl[5].s.rde = 0; tbl[5].s.rs2d = 0;
        tbl[6].s = tbl[4].s; tbl[6].s.use2 = 0;
        tbl[7].s.ld = 1; tbl[7].s.rwe = 1; tbl[7].s.rde = 7; tbl[7].s.rs1d = 7; tbl[7].s.use1 = 1;
        tbl[7].stallF = 1; tbl[7].flushE = 1;
        tbl[8].s = tbl[7].s; tbl[8].s.rwe = 0;
        tbl[9].s = tbl[4].s; tbl[9].s.pc = 1;
        tbl[9].stallF = 1; tbl[9].flushD = 1; tbl[9].flushE = 1;

        lwS = tbl[4].s;
        clrS = idleStim(); clrS.clr = 1;
        startS = idleStim(); startS.start = 1;
        rstS = idleStim(); rstS.rst = 1;

        step(rstS);
        step(rstS);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].s);
            checkOutput($sformatf("tbl%0d_fwd_a", i), 16'(fwdA), 16'(tbl[i].fa));
            checkOutput($sformatf("tbl%0d_fwd_b", i), 16'(fwdB), 16'(tbl[i].fb));
            checkOutput($sformatf("tbl%0d_stall_f", i), 16'(stallF), 16'(tbl[i].stallF));
            checkOutput($sformatf("tbl%0d_flush_d", i), 16'(flushD), 16'(tbl[i].flushD));
            checkOutput($sformatf("tbl%0d_flush_e", i), 16'(flushE), 16'(tbl[i].flushE));
            advance();
        end

        // MDU held: 3 stall cycles, no re-trigger, then back-to-back op re-arms once E reloads
        startSeq = '{1, 1, 1, 1, 1, 0, 0, 0};
        expStE   = '{1, 1, 1, 0, 1, 1, 1, 0};
        expBusy  = '{0, 1, 1, 0, 0, 1, 1, 0};
        step(clrS);
        for (int i = 0; i < 8; i++) begin
            s = idleStim(); s.start = startSeq[i];
            applyStimulus(s);
            checkOutput($sformatf("mdu%0d_stall_e", i), 16'(stallE), 16'(expStE[i]));
            checkOutput($sformatf("mdu%0d_flush_m", i), 16'(flushM), 16'(expStE[i]));
            checkOutput($sformatf("mdu%0d_busy", i), 16'(mduBusy), 16'(expBusy[i]));
            advance();
        end

        step(clrS);
        s = lwS; s.pc = 1;
        applyStimulus(s);
        checkOutput("pc_lw_flush_d", 16'(flushD), 16'd1);
        checkOutput("pc_lw_flush_e", 16'(flushE), 16'd1);
        advance();
        applyStimulus(idleStim());
        checkOutput("pc_lw_flush_cnt", 16'(flushCnt), 16'd1);
        advance();

        step(clrS);
        for (int i = 0; i < 20; i++) step(lwS);
        applyStimulus(idleStim());
        checkOutput("stall_cnt_sat", 16'(stallCnt), 16'd15);
        advance();
        step(clrS);
        applyStimulus(idleStim());
        checkOutput("stall_cnt_clr", 16'(stallCnt), 16'd0);
        advance();

        step(startS);
        step(startS);
        s = startS; s.rst = 1;
        applyStimulus(s);
        checkOutput("rst_busy_flush_d", 16'(flushD), 16'd1);
        checkOutput("rst_busy_flush_e", 16'(flushE), 16'd1);
        checkOutput("rst_busy_flush_m", 16'(flushM), 16'd1);
        checkOutput("rst_busy_stall_f", 16'(stallF), 16'd0);
        checkOutput("rst_busy_stall_e", 16'(stallE), 16'd0);
        advance();
        applyStimulus(idleStim());
        checkOutput("post_rst_busy", 16'(mduBusy), 16'd0);
        checkOutput("post_rst_stall_cnt", 16'(stallCnt), 16'd0);
        checkOutput("post_rst_flush_cnt", 16'(flushCnt), 16'd0);
        advance();

        prevStart = 0;
        for (int i = 0; i < 3000; i++) begin
            s = randStim(prevStart);
            prevStart = s.start;
            step(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
